// File: rtl/shift_issue_stage.sv
// Decode/issue stage feeding the execute-stage shifter.
// Decodes R-type shift instructions, picks the shift amount (shamt or rs[4:0]),
// and presents the result to EX through a registered 2-entry skid buffer so that
// in_ready comes straight from a flop.
module shift_issue_stage #(
    parameter bit FLUSH_KEEPS_SKID = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_value,
    output logic [1:0]  out_shiftop,
    output logic [4:0]  out_shiftamt,
    output logic [4:0]  out_rd,
    output logic        out_wr_en,
    output logic        out_illegal
);

    typedef struct packed {
        logic [31:0] value;
        logic [1:0]  shiftop;
        logic [4:0]  amt;
        logic [4:0]  rd;
        logic        wr_en;
        logic        illegal;
    } word_t;

    localparam logic [1:0] OpSrl  = 2'b00;
    localparam logic [1:0] OpSra  = 2'b01;
    localparam logic [1:0] OpSll  = 2'b10;
    localparam logic [1:0] OpPass = 2'b11;

    localparam word_t RstWord = '{
        value:   32'd0,
        shiftop: OpPass,
        amt:     5'd0,
        rd:      5'd0,
        wr_en:   1'b0,
        illegal: 1'b0
    };

    // Instruction fields
    logic [5:0] op;
    logic [4:0] rd;
    logic [4:0] sa;
    logic [5:0] funct;

    assign op    = in_instr[31:26];
    assign rd    = in_instr[15:11];
    assign sa    = in_instr[10:6];
    assign funct = in_instr[5:0];

    // rs/rt register numbers are resolved upstream; only rs_val[4:0] matters here
    logic unused_bits;
    assign unused_bits = ^{in_instr[25:16], in_rs_val[31:5]};

    word_t dec;
    word_t out_q, out_d;
    word_t skid_q, skid_d;
    logic  out_valid_q, out_valid_d;
    logic  skid_full_q, skid_full_d;

    // Decode the incoming word; non-shift words pass rt_val through unchanged
    always_comb begin
        dec       = RstWord;
        dec.value = in_rt_val;
        if (op == 6'd0) begin
            dec.rd    = rd;
            dec.wr_en = (rd != 5'd0);
            case (funct)
                6'b000000: begin dec.shiftop = OpSll; dec.amt = sa;             end
                6'b000010: begin dec.shiftop = OpSrl; dec.amt = sa;             end
                6'b000011: begin dec.shiftop = OpSra; dec.amt = sa;             end
                6'b000100: begin dec.shiftop = OpSll; dec.amt = in_rs_val[4:0]; end
                6'b000110: begin dec.shiftop = OpSrl; dec.amt = in_rs_val[4:0]; end
                6'b000111: begin dec.shiftop = OpSra; dec.amt = in_rs_val[4:0]; end
                default: begin
                    dec.rd      = 5'd0;
                    dec.wr_en   = 1'b0;
                    dec.illegal = 1'b1;
                end
            endcase
        end
    end

    logic in_xfer;
    logic out_load;

    assign in_xfer  = in_valid & ~skid_full_q;
    // Output register can take a new word when it is empty or being drained
    assign out_load = ~out_valid_q | out_ready;

    // Skid buffer next-state: skid entry always drains before a fresh input word
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        skid_full_d = skid_full_q;
        skid_d      = skid_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_d       = RstWord;
            if (!FLUSH_KEEPS_SKID) begin
                skid_full_d = 1'b0;
                skid_d      = RstWord;
            end
        end else if (out_load) begin
            if (skid_full_q) begin
                out_valid_d = 1'b1;
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end else if (in_xfer) begin
                out_valid_d = 1'b1;
                out_d       = dec;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_full_d = 1'b1;
            skid_d      = dec;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= RstWord;
            skid_full_q <= 1'b0;
            skid_q      <= RstWord;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            skid_full_q <= skid_full_d;
            skid_q      <= skid_d;
        end
    end

    assign in_ready     = ~skid_full_q;
    assign out_valid    = out_valid_q;
    assign out_value    = out_q.value;
    assign out_shiftop  = out_q.shiftop;
    assign out_shiftamt = out_q.amt;
    assign out_rd       = out_q.rd;
    assign out_wr_en    = out_q.wr_en;
    assign out_illegal  = out_q.illegal;

endmodule
